// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, multiply FSM states, flag bit positions.
package ex_stage_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_PASSA = 4'd9;
    localparam logic [3:0] OP_PASSB = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_MUL  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exState_t;

    // Positions inside the {Z,N,C,V} flag vector
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for all single-cycle ops. MUL and the reserved codes yield result 0, flags 0;
// the multiply is handled iteratively by the enclosing stage.
module ex_stage_alu
    import ex_stage_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        aluOp,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] wide;
    logic            carry;
    logic            ovf;
    logic            known;

    // Operation select; carry/overflow only come from the add/subtract paths
    always_comb begin
        wide   = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        known  = 1'b1;
        case (aluOp)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = wide[DATA_W];
                ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[DATA_W-1:0];
                carry  = ~wide[DATA_W];
                ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
            end
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NOT:   result = ~a;
            OP_SHL:   result = a << b[3:0];
            OP_SHR:   result = a >> b[3:0];
            OP_SRA:   result = $unsigned($signed(a) >>> b[3:0]);
            OP_PASSA: result = a;
            OP_PASSB: result = b;
            OP_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  known  = 1'b0;
        endcase

        flags = '0;
        if (known) begin
            flags[FLAG_Z] = (result == '0);
            flags[FLAG_N] = result[MSB];
            flags[FLAG_C] = carry;
            flags[FLAG_V] = ovf;
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier, feeding the
// EX/MEM output register. While a multiply runs, o_busy holds the ID/EX latch.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int MUL_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] readData0,
    input  logic [DATA_W-1:0] readData1,
    input  logic [3:0]        ALUOp,
    input  logic              ReadMem,
    input  logic              WriteMem,
    input  logic [DATA_W-1:0] DataIn,
    input  logic [1:0]        quarter,
    input  logic              write,
    input  logic [4:0]        writeReg,
    input  logic              flush,
    input  logic              mem_stall,
    output logic              o_busy,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_aluResult,
    output logic [3:0]        o_flags,
    output logic              o_ReadMem,
    output logic              o_WriteMem,
    output logic [DATA_W-1:0] o_DataIn,
    output logic [1:0]        o_quarter,
    output logic              o_write,
    output logic [4:0]        o_writeReg
);

    localparam int STEPS = DATA_W / MUL_BITS;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    exState_t          state, stateNext;
    logic              accept, mulAccept, mulStep, mulLoad;
    logic [DATA_W-1:0] mulA, mulB, acc, partial;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] aluResult;
    logic [3:0]        aluFlags, mulFlags;

    logic              hReadMem, hWriteMem, hWrite;
    logic [DATA_W-1:0] hDataIn;
    logic [1:0]        hQuarter;
    logic [4:0]        hWriteReg;

    ex_stage_alu #(.DATA_W(DATA_W)) uAlu (
        .a      (readData0),
        .b      (readData1),
        .aluOp  (ALUOp),
        .result (aluResult),
        .flags  (aluFlags)
    );

    assign accept    = in_valid && (state == ST_IDLE) && !mem_stall && !flush;
    assign mulAccept = accept && (ALUOp == OP_MUL);
    // Multiplicand pre-shifted, so each step only needs the low MUL_BITS of the multiplier
    assign partial   = mulA * DATA_W'(mulB[MUL_BITS-1:0]);

    // Multiply result flags: Z/N only
    always_comb begin
        mulFlags         = '0;
        mulFlags[FLAG_Z] = (acc == '0);
        mulFlags[FLAG_N] = acc[DATA_W-1];
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= stateNext;
    end

    // FSM next-state; flush wins over everything but reset
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (mulAccept) stateNext = ST_MUL;
            ST_MUL:  if (cnt == '0) stateNext = ST_DONE;
            ST_DONE: if (!mem_stall) stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
        if (flush) stateNext = ST_IDLE;
    end

    // FSM outputs
    always_comb begin
        o_busy  = (state != ST_IDLE);
        mulStep = (state == ST_MUL);
        mulLoad = (state == ST_DONE) && !mem_stall && !flush;
    end

    // Multiplier datapath: operand/control capture on accept, one partial-product step per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mulA      <= '0;
            mulB      <= '0;
            acc       <= '0;
            cnt       <= '0;
            hReadMem  <= 1'b0;
            hWriteMem <= 1'b0;
            hDataIn   <= '0;
            hQuarter  <= '0;
            hWrite    <= 1'b0;
            hWriteReg <= '0;
        end else if (mulAccept) begin
            mulA      <= readData0;
            mulB      <= readData1;
            acc       <= '0;
            cnt       <= CNT_LAST;
            hReadMem  <= ReadMem;
            hWriteMem <= WriteMem;
            hDataIn   <= DataIn;
            hQuarter  <= quarter;
            hWrite    <= write;
            hWriteReg <= writeReg;
        end else if (mulStep && !flush) begin
            acc  <= acc + partial;
            mulA <= mulA << MUL_BITS;
            mulB <= mulB >> MUL_BITS;
            if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
    end

    // EX/MEM register: flush > mem_stall > multiply completion > single-cycle accept > bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid     <= 1'b0;
            o_aluResult <= '0;
            o_flags     <= '0;
            o_ReadMem   <= 1'b0;
            o_WriteMem  <= 1'b0;
            o_DataIn    <= '0;
            o_quarter   <= '0;
            o_write     <= 1'b0;
            o_writeReg  <= '0;
        end else if (flush) begin
            if (!mem_stall) o_valid <= 1'b0;
        end else if (mem_stall) begin
            o_valid <= o_valid;
        end else if (mulLoad) begin
            o_valid     <= 1'b1;
            o_aluResult <= acc;
            o_flags     <= mulFlags;
            o_ReadMem   <= hReadMem;
            o_WriteMem  <= hWriteMem;
            o_DataIn    <= hDataIn;
            o_quarter   <= hQuarter;
            o_write     <= hWrite;
            o_writeReg  <= hWriteReg;
        end else if (accept && !mulAccept) begin
            o_valid     <= 1'b1;
            o_aluResult <= aluResult;
            o_flags     <= aluFlags;
            o_ReadMem   <= ReadMem;
            o_WriteMem  <= WriteMem;
            o_DataIn    <= DataIn;
            o_quarter   <= quarter;
            o_write     <= write;
            o_writeReg  <= writeReg;
        end else begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed vectors, a behavioural reference model compared every cycle,
// and hand-computed literal expectations for the key cases.
module tb_ex_stage;

    localparam int W     = 16;
    localparam int STEPS = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  readData0 = '0, readData1 = '0, DataIn = '0;
    logic [3:0]    ALUOp = '0;
    logic          ReadMem = 1'b0, WriteMem = 1'b0, write = 1'b0;
    logic [1:0]    quarter = '0;
    logic [4:0]    writeReg = '0;
    logic          flush = 1'b0, mem_stall = 1'b0;

    logic          o_busy, o_valid, o_ReadMem, o_WriteMem, o_write;
    logic [W-1:0]  o_aluResult, o_DataIn;
    logic [3:0]    o_flags;
    logic [1:0]    o_quarter;
    logic [4:0]    o_writeReg;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .readData0(readData0), .readData1(readData1), .ALUOp(ALUOp),
        .ReadMem(ReadMem), .WriteMem(WriteMem), .DataIn(DataIn),
        .quarter(quarter), .write(write), .writeReg(writeReg),
        .flush(flush), .mem_stall(mem_stall),
        .o_busy(o_busy), .o_valid(o_valid), .o_aluResult(o_aluResult), .o_flags(o_flags),
        .o_ReadMem(o_ReadMem), .o_WriteMem(o_WriteMem), .o_DataIn(o_DataIn),
        .o_quarter(o_quarter), .o_write(o_write), .o_writeReg(o_writeReg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU straight from the op definitions, using integer arithmetic
    function automatic void refAlu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] r, output logic [3:0] f);
        int unsigned ua, ub, us;
        int sa, sb, ss;
        logic c, v;
        logic [W-1:0] t;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = 1'b0; v = 1'b0; r = '0;
        case (op)
            4'd0: begin us = ua + ub; r = us[W-1:0]; c = (us > 65535); ss = sa + sb; v = (ss > 32767) || (ss < -32768); end
            4'd1: begin us = ua - ub; r = us[W-1:0]; c = (ua >= ub);   ss = sa - sb; v = (ss > 32767) || (ss < -32768); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: begin us = ua * (32'd1 << b[3:0]); r = us[W-1:0]; end
            4'd7: begin us = ua / (32'd1 << b[3:0]); r = us[W-1:0]; end
            4'd8: begin t = a; for (int i = 0; i < int'(b[3:0]); i++) t = {t[W-1], t[W-1:1]}; r = t; end
            4'd9: r = a;
            4'd10: r = b;
            4'd11: r = (sa < sb) ? 16'd1 : 16'd0;
            4'd12: begin us = ua * ub; r = us[W-1:0]; end
            default: r = '0;
        endcase
        if (op <= 4'd12) f = {(r == '0), r[W-1], c, v};
        else             f = 4'b0000;
    endfunction

    // Model state: expected outputs plus edges left until a multiply may retire (0 = no multiply)
    int           mLeft = 0;
    logic         mValid = 0, mRm = 0, mWm = 0, mW = 0;
    logic [W-1:0] mRes = '0, mDin = '0;
    logic [3:0]   mFlags = '0;
    logic [1:0]   mQ = '0;
    logic [4:0]   mWr = '0;
    logic [W-1:0] pRes = '0, pDin = '0;
    logic [3:0]   pFlags = '0;
    logic         pRm = 0, pWm = 0, pW = 0;
    logic [1:0]   pQ = '0;
    logic [4:0]   pWr = '0;

    initial forever begin
        logic [W-1:0] r;
        logic [3:0]   f;
        @(posedge clk);
        if (rst) begin
            mLeft = 0; mValid = 0; mRes = '0; mFlags = '0;
            mRm = 0; mWm = 0; mDin = '0; mQ = '0; mW = 0; mWr = '0;
        end else if (flush) begin
            mLeft = 0;
            if (!mem_stall) mValid = 0;
        end else if (mem_stall) begin
            if (mLeft > 1) mLeft--;
        end else if (mLeft == 1) begin
            mLeft = 0; mValid = 1; mRes = pRes; mFlags = pFlags;
            mRm = pRm; mWm = pWm; mDin = pDin; mQ = pQ; mW = pW; mWr = pWr;
        end else if (mLeft > 1) begin
            mLeft--; mValid = 0;
        end else if (in_valid) begin
            refAlu(ALUOp, readData0, readData1, r, f);
            if (ALUOp == 4'd12) begin
                mLeft = STEPS + 1; mValid = 0; pRes = r; pFlags = f;
                pRm = ReadMem; pWm = WriteMem; pDin = DataIn; pQ = quarter; pW = write; pWr = writeReg;
            end else begin
                mValid = 1; mRes = r; mFlags = f;
                mRm = ReadMem; mWm = WriteMem; mDin = DataIn; mQ = quarter; mW = write; mWr = writeReg;
            end
        end else begin
            mValid = 0;
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(posedge clk);
        #2;
        chk("m_busy", o_busy, (mLeft != 0));
        chk("m_valid", o_valid, mValid);
        chk("m_result", o_aluResult, mRes);
        chk("m_flags", o_flags, mFlags);
        chk("m_ctrl", {o_ReadMem, o_WriteMem, o_write, o_quarter, o_writeReg}, {mRm, mWm, mW, mQ, mWr});
        chk("m_datain", o_DataIn, mDin);
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic rm, input logic wm, input logic [W-1:0] din,
                         input logic [1:0] q, input logic w, input logic [4:0] wr);
        @(negedge clk);
        in_valid = 1'b1; ALUOp = op; readData0 = a; readData1 = b;
        ReadMem = rm; WriteMem = wm; DataIn = din; quarter = q; write = w; writeReg = wr;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic after();
        @(posedge clk);
        #2;
    endtask

    initial begin
        // 1. reset
        repeat (2) @(posedge clk);
        #2;
        chk("rst_valid", o_valid, 0);
        chk("rst_result", o_aluResult, 0);
        chk("rst_flags", o_flags, 0);
        @(negedge clk); rst = 1'b0;
        after();
        chk("rst_busy", o_busy, 0);
        chk("rst_ctrl", {o_ReadMem, o_WriteMem, o_write, o_quarter, o_writeReg, o_DataIn}, 0);

        // 2. ADD overflow, SUB borrow
        issue(4'd0, 16'h7FFF, 16'h0001, 0, 0, 16'h0, 2'd0, 0, 5'd0);
        after();
        chk("add_valid", o_valid, 1);
        chk("add_result", o_aluResult, 16'h8000);
        chk("add_flags", o_flags, 4'b0101);
        issue(4'd1, 16'h0003, 16'h0005, 0, 0, 16'h0, 2'd0, 0, 5'd0);
        after();
        chk("sub_result", o_aluResult, 16'hFFFE);
        chk("sub_flags", o_flags, 4'b0100);

        // 3. forwarded controls, back-to-back
        issue(4'd0, 16'h0010, 16'h0020, 1, 0, 16'hBEEF, 2'b10, 1, 5'd9);
        after();
        chk("fwd_readmem", o_ReadMem, 1);
        chk("fwd_writereg", o_writeReg, 9);
        chk("fwd_quarter", o_quarter, 2);
        issue(4'd2, 16'hF0F0, 16'h0FF0, 0, 1, 16'h1234, 2'b01, 0, 5'd3);
        after();
        chk("b2b_valid", o_valid, 1);
        chk("b2b_result", o_aluResult, 16'h00F0);
        issue(4'd3,  16'hA000, 16'h0005, 0, 0, 16'h0, 2'd0, 1, 5'd1);
        issue(4'd4,  16'hFFFF, 16'h00FF, 0, 0, 16'h0, 2'd0, 1, 5'd2);
        issue(4'd5,  16'hFFFF, 16'h0000, 0, 0, 16'h0, 2'd0, 1, 5'd3);
        issue(4'd6,  16'h0001, 16'h000F, 0, 0, 16'h0, 2'd0, 1, 5'd4);
        issue(4'd7,  16'h8000, 16'h0004, 0, 0, 16'h0, 2'd0, 1, 5'd5);
        issue(4'd8,  16'h8000, 16'h0004, 0, 0, 16'h0, 2'd0, 1, 5'd6);
        after();
        chk("sra_result", o_aluResult, 16'hF800);
        issue(4'd9,  16'h1357, 16'h2468, 0, 0, 16'h0, 2'd0, 1, 5'd7);
        issue(4'd10, 16'h1357, 16'h2468, 0, 0, 16'h0, 2'd0, 1, 5'd8);
        issue(4'd11, 16'hFFFF, 16'h0001, 0, 0, 16'h0, 2'd0, 1, 5'd9);
        after();
        chk("slt_result", o_aluResult, 16'h0001);
        issue(4'd1, 16'h8000, 16'h0001, 0, 0, 16'h0, 2'd0, 0, 5'd0);
        issue(4'd0, 16'hFFFF, 16'h0001, 0, 0, 16'h0, 2'd0, 0, 5'd0);
        after();
        chk("add_carry_flags", o_flags, 4'b1010);
        issue(4'd13, 16'hFFFF, 16'hFFFF, 0, 0, 16'h5555, 2'd3, 1, 5'd31);
        after();
        chk("rsv_result", o_aluResult, 0);
        chk("rsv_flags", o_flags, 0);
        chk("rsv_writereg", o_writeReg, 31);

        // 4. MUL latency
        issue(4'd12, 16'h0013, 16'h0021, 0, 0, 16'h0, 2'd1, 1, 5'd12);
        after();
        chk("mul_busy_E", o_busy, 1);
        for (int k = 1; k <= 16; k++) begin
            idle();
            after();
            chk("mul_busy", o_busy, 1);
            chk("mul_nvalid", o_valid, 0);
        end
        idle();
        after();
        chk("mul_result", o_aluResult, 16'h0273);
        chk("mul_valid", o_valid, 1);
        chk("mul_busy_end", o_busy, 0);
        chk("mul_writereg", o_writeReg, 12);

        // 5. MUL held in DONE by mem_stall
        issue(4'd0, 16'h0001, 16'h0002, 0, 0, 16'h0, 2'd0, 0, 5'd0);
        issue(4'd12, 16'h0013, 16'h0021, 0, 0, 16'h0, 2'd0, 0, 5'd0);
        after();
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            mem_stall = (k >= 10 && k <= 20);
            after();
            if (k == 20) begin
                chk("stall_hold_result", o_aluResult, 16'h0003);
                chk("stall_busy", o_busy, 1);
            end
            if (k == 21) begin
                chk("stall_mul_result", o_aluResult, 16'h0273);
                chk("stall_mul_valid", o_valid, 1);
            end
        end

        // 6. flush during MUL, then a normal ADD
        issue(4'd12, 16'h00FF, 16'h00FF, 0, 0, 16'h0, 2'd0, 0, 5'd0);
        after();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            flush = (k == 5);
            after();
        end
        chk("flush_busy", o_busy, 0);
        chk("flush_valid", o_valid, 0);
        @(negedge clk); flush = 1'b0;
        issue(4'd0, 16'h1234, 16'h0001, 0, 0, 16'h0, 2'd0, 1, 5'd2);
        after();
        chk("post_flush_result", o_aluResult, 16'h1235);
        chk("post_flush_valid", o_valid, 1);

        // flush together with mem_stall keeps the EX/MEM register
        @(negedge clk);
        flush = 1'b1; mem_stall = 1'b1;
        after();
        chk("flush_stall_valid", o_valid, 1);
        @(negedge clk);
        flush = 1'b0; mem_stall = 1'b0; in_valid = 1'b0;
        repeat (3) after();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
